note_sequencer: RTL and testbench

// - Record/playback controller for the note datapath. Sits between the push buttons and the datapath;

---
 rtl/music_pkg.sv | 30 +++
 rtl/btn_edge.sv | 41 ++++
 rtl/note_sequencer.sv | 176 +++++++++++++++++
 tb/tb_note_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the note record/playback controller.
package music_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY_NOTE = 2'd1,
    ST_PLAY_GAP  = 2'd2,
    ST_FINISH    = 2'd3
  } st_e;

  // Board defaults: 0.25 s note and 0.05 s gap at 50 MHz.
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_NOTE_TICKS = 12_500_000;
  localparam int DEF_GAP_TICKS  = 2_500_000;

  // Bits needed to hold the values 0..v-1.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Push-button front end: 2-FF synchronizer followed by a registered
// falling-edge detector. One press gives exactly one single-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic pulse_q, pulse_d;

  // Shift the raw level through the synchronizer and flag a high-to-low step.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = prev_q & ~sync2_q;
  end

  // Idle level of the buttons is high, so the chain resets to 1 to avoid a
  // spurious press right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/note_sequencer.sv
// Record/playback scheduler for the note datapath: records switch notes into
// consecutive slots on load presses and plays them back with timed note/gap
// phases, optionally looping. A play press during playback stops it.
module note_sequencer
  import music_pkg::*;
#(
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int NOTE_TICKS = DEF_NOTE_TICKS,
  parameter  int GAP_TICKS  = DEF_GAP_TICKS,
  parameter  int LOOP       = 0,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_n,
  input  logic              playback_n,
  output logic              ld_note,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              ld_play,
  output logic [ADDR_W-1:0] note_counter,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              done
);

  localparam int TICK_W = clog2_f(max_f(NOTE_TICKS, GAP_TICKS) + 1);
  localparam logic [TICK_W-1:0] NOTE_LAST = TICK_W'(NOTE_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  logic load_pulse, play_pulse;

  btn_edge u_load_edge (
    .clk   (clk),
    .reset (reset),
    .btn_n (load_n),
    .pulse (load_pulse)
  );

  btn_edge u_play_edge (
    .clk   (clk),
    .reset (reset),
    .btn_n (playback_n),
    .pulse (play_pulse)
  );

  st_e               state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] note_counter_q, note_counter_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              ld_note_q, ld_note_d;
  logic              ld_play_q, ld_play_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Where playback goes once the current slot's note (and gap) has elapsed.
  logic [ADDR_W:0]   next_slot;
  logic              last_slot;
  st_e               adv_state;
  logic [ADDR_W-1:0] adv_counter;

  // Next-state, slot counters and registered outputs of the sequencer.
  always_comb begin
    next_slot   = {1'b0, note_counter_q} + 1'b1;
    last_slot   = (next_slot == count_q);
    adv_state   = ST_PLAY_NOTE;
    adv_counter = note_counter_q + 1'b1;
    if (last_slot) begin
      adv_counter = '0;
      adv_state   = (LOOP != 0) ? ST_PLAY_NOTE : ST_FINISH;
      if (LOOP == 0) adv_counter = note_counter_q;
    end

    state_d        = state_q;
    tick_d         = tick_q + 1'b1;
    count_d        = count_q;
    note_counter_d = note_counter_q;
    wr_addr_d      = wr_addr_q;
    ld_note_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        // Load has priority; a simultaneous play press is dropped.
        if (load_pulse) begin
          if (count_q != DEPTH_C) begin
            ld_note_d = 1'b1;
            wr_addr_d = count_q[ADDR_W-1:0];
            count_d   = count_q + 1'b1;
          end
        end else if (play_pulse && (count_q != '0)) begin
          note_counter_d = '0;
          state_d        = ST_PLAY_NOTE;
        end
      end
      ST_PLAY_NOTE: begin
        if (play_pulse) begin
          state_d        = ST_IDLE;
          note_counter_d = '0;
          tick_d         = '0;
        end else if (tick_q == NOTE_LAST) begin
          tick_d = '0;
          if (GAP_TICKS > 0) begin
            state_d = ST_PLAY_GAP;
          end else begin
            state_d        = adv_state;
            note_counter_d = adv_counter;
          end
        end
      end
      ST_PLAY_GAP: begin
        if (play_pulse) begin
          state_d        = ST_IDLE;
          note_counter_d = '0;
          tick_d         = '0;
        end else if (tick_q == GAP_LAST) begin
          tick_d         = '0;
          state_d        = adv_state;
          note_counter_d = adv_counter;
        end
      end
      ST_FINISH: begin
        state_d        = ST_IDLE;
        note_counter_d = '0;
        tick_d         = '0;
      end
      default: begin
        state_d        = ST_IDLE;
        note_counter_d = '0;
        tick_d         = '0;
      end
    endcase

    // Outputs follow the next state so they line up with the state register.
    ld_play_d = (state_d == ST_PLAY_NOTE);
    done_d    = (state_d == ST_FINISH);
    busy_d    = (state_d != ST_IDLE);
  end

  // State, counters and output registers; reset drops the recorded notes too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      tick_q         <= '0;
      count_q        <= '0;
      note_counter_q <= '0;
      wr_addr_q      <= '0;
      ld_note_q      <= 1'b0;
      ld_play_q      <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      count_q        <= count_d;
      note_counter_q <= note_counter_d;
      wr_addr_q      <= wr_addr_d;
      ld_note_q      <= ld_note_d;
      ld_play_q      <= ld_play_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
    end
  end

  assign ld_note      = ld_note_q;
  assign wr_addr      = wr_addr_q;
  assign ld_play      = ld_play_q;
  assign note_counter = note_counter_q;
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: one non-looping and one looping instance,
// with write strobes and playback traces checked against queued expectations.
module tb_note_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_n = 1'b1, play_n = 1'b1;
  logic lload_n = 1'b1, lplay_n = 1'b1;

  logic          ld_note, ld_play, full, busy, done;
  logic [AW-1:0] wr_addr, nc;
  logic [AW:0]   count;
  logic          l_ld_note, l_ld_play, l_full, l_busy, l_done;
  logic [AW-1:0] l_wr_addr, l_nc;
  logic [AW:0]   l_count;

  always #5 clk = ~clk;

  note_sequencer #(.DEPTH(DEPTH), .NOTE_TICKS(5), .GAP_TICKS(2), .LOOP(0)) dut (
    .clk(clk), .reset(reset), .load_n(load_n), .playback_n(play_n),
    .ld_note(ld_note), .wr_addr(wr_addr), .ld_play(ld_play), .note_counter(nc),
    .count(count), .full(full), .busy(busy), .done(done)
  );

  note_sequencer #(.DEPTH(DEPTH), .NOTE_TICKS(5), .GAP_TICKS(2), .LOOP(1)) dut_lp (
    .clk(clk), .reset(reset), .load_n(lload_n), .playback_n(lplay_n),
    .ld_note(l_ld_note), .wr_addr(l_wr_addr), .ld_play(l_ld_play), .note_counter(l_nc),
    .count(l_count), .full(l_full), .busy(l_busy), .done(l_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          lp;
    logic [AW-1:0] nc;
    logic          dn;
    logic          bs;
  } play_t;

  int    exp_addr_q[$];
  int    exp_laddr_q[$];
  play_t exp_play_q[$];
  int    m_count  = 0;
  int    ml_count = 0;
  bit    ml_busy  = 0;
  bit    lp_done_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Write strobe scoreboards
  always @(negedge clk) begin
    if (ld_note === 1'b1) begin
      if (exp_addr_q.size() == 0) check("ld_note_unexpected", 32'd1, 32'd0);
      else check("wr_addr", 32'(wr_addr), 32'(exp_addr_q.pop_front()));
    end
    if (l_ld_note === 1'b1) begin
      if (exp_laddr_q.size() == 0) check("lp_ld_note_unexpected", 32'd1, 32'd0);
      else check("lp_wr_addr", 32'(l_wr_addr), 32'(exp_laddr_q.pop_front()));
    end
    if (l_done === 1'b1) lp_done_seen = 1'b1;
  end

  task automatic press_load();
    @(posedge clk); #1 load_n = 1'b0;
    if (m_count < DEPTH) begin
      exp_addr_q.push_back(m_count);
      m_count++;
    end
    repeat (6) @(posedge clk);
    #1 load_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic press_lload();
    @(posedge clk); #1 lload_n = 1'b0;
    if (!ml_busy && ml_count < DEPTH) begin
      exp_laddr_q.push_back(ml_count);
      ml_count++;
    end
    repeat (6) @(posedge clk);
    #1 lload_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_play(input bit lp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((lp ? l_ld_play : ld_play) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_trace(input bit lp);
    play_t e;
    while (exp_play_q.size() > 0) begin
      e = exp_play_q.pop_front();
      if (lp) check("lp_trace", 32'({l_ld_play, l_nc, l_done, l_busy}), 32'(e));
      else    check("trace",    32'({ld_play, nc, done, busy}), 32'(e));
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int busy_seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({ld_note, wr_addr, ld_play, nc, count, full, busy, done}), 32'd0);
    check("lp_reset_outputs", 32'({l_ld_note, l_wr_addr, l_ld_play, l_nc, l_count, l_full, l_busy, l_done}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Play with an empty store is ignored
    @(posedge clk); #1 play_n = 1'b0;
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen++;
    end
    check("empty_play_busy", busy_seen, 0);
    @(posedge clk); #1 play_n = 1'b1;
    repeat (4) @(posedge clk);

    // Record three notes
    repeat (3) press_load();
    check("count_after3", 32'(count), 32'd3);
    check("full_after3", 32'(full), 32'd0);
    check("strobes_pending", exp_addr_q.size(), 0);

    // Full playback of three slots; button held throughout (no repeat pulse)
    @(posedge clk); #1 play_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      repeat (5) exp_play_q.push_back('{1'b1, AW'(s), 1'b0, 1'b1});
      repeat (2) exp_play_q.push_back('{1'b0, AW'(s), 1'b0, 1'b1});
    end
    exp_play_q.push_back('{1'b0, AW'(2), 1'b1, 1'b1});
    repeat (3) exp_play_q.push_back('{1'b0, AW'(0), 1'b0, 1'b0});
    wait_play(1'b0, ok);
    check("play_start", 32'(ok), 32'd1);
    if (ok) run_trace(1'b0);
    else exp_play_q.delete();
    @(posedge clk); #1 play_n = 1'b1;
    repeat (4) @(posedge clk);
    check("count_kept", 32'(count), 32'd3);

    // Fill the store: only one more slot is free
    repeat (3) press_load();
    check("count_full", 32'(count), 32'd4);
    check("full_flag", 32'(full), 32'd1);
    check("strobes_pending_full", exp_addr_q.size(), 0);

    // Looping playback on the second instance
    repeat (3) press_lload();
    check("lp_count", 32'(l_count), 32'd3);
    @(posedge clk); #1 lplay_n = 1'b0;
    for (int k = 0; k < 40; k++)
      exp_play_q.push_back('{((k % 7) < 5), AW'((k / 7) % 3), 1'b0, 1'b1});
    wait_play(1'b1, ok);
    check("lp_play_start", 32'(ok), 32'd1);
    if (ok) run_trace(1'b1);
    else exp_play_q.delete();
    @(posedge clk); #1 lplay_n = 1'b1;

    // Load during playback is ignored
    ml_busy = 1'b1;
    press_lload();
    check("lp_count_frozen", 32'(l_count), 32'd3);
    check("lp_still_busy", 32'(l_busy), 32'd1);
    check("lp_strobes_pending", exp_laddr_q.size(), 0);

    // A second play press stops the loop
    @(posedge clk); #1 lplay_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (l_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("lp_stop", 32'(ok), 32'd1);
    check("lp_stop_outputs", 32'({l_ld_play, l_nc, l_done}), 32'd0);
    @(posedge clk); #1 lplay_n = 1'b1;
    ml_busy = 1'b0;
    repeat (10) @(posedge clk);
    check("lp_done_never", 32'(lp_done_seen), 32'd0);
    check("lp_idle_after_stop", 32'(l_busy), 32'd0);

    // Asynchronous reset in the middle of a note
    @(posedge clk); #1 play_n = 1'b0;
    wait_play(1'b0, ok);
    check("play_start_full", 32'(ok), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", 32'({ld_note, wr_addr, ld_play, nc, count, full, busy, done}), 32'd0);
    m_count = 0;
    exp_addr_q.delete();
    @(posedge clk); #1 play_n = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    // Recording restarts from slot 0; six presses give four strobes
    repeat (6) press_load();
    check("count_after_reset", 32'(count), 32'd4);
    check("full_after_reset", 32'(full), 32'd1);
    check("strobes_pending_reset", exp_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
